// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan test controller: FSM state encoding and counter sizing.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_e;

  // Width able to hold values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load / serial-shift register; shifts toward the MSB, serial data enters at bit 0.
module scan_shreg #(
  parameter int W = 5
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] par_i,
  input  logic         ser_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] q_q;

  // Value after one shift; lets the owner register the fully assembled word on the final shift.
  assign nxt_o = {q_q[W-2:0], ser_i};
  assign q_o   = q_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)      q_q <= '0;
    else if (load_i)  q_q <= par_i;
    else if (shift_i) q_q <= nxt_o;
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan controller: shift a pattern in, capture functionally, shift out and compare.
// Optional compare against expect_in is built only when SCAN_CMP_EN is defined.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 5,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic                 Scan_so,
  output logic                 Scan_en,
  output logic                 Scan_si,
  output logic                 cg_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] capture_out
);

  localparam int CW = cnt_w(CHAIN_LEN > CAP_CYCLES ? CHAIN_LEN : CAP_CYCLES);
  localparam logic [CW-1:0] LEN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAP_CYCLES - 1);

  scan_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 accept;
  logic                 pass_d;
  logic                 se_q, cg_q, busy_q, done_q, pass_q;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] pat_q, unl_nxt;
  logic [CHAIN_LEN-1:0] unused_pat_nxt, unused_unl_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT_IN;
        end
      end
      SHIFT_IN: if (cnt_q == LEN_LAST) begin
        state_d = CAPTURE;
        cnt_d   = '0;
      end
      CAPTURE: if (cnt_q == CAP_LAST) begin
        state_d = SHIFT_OUT;
        cnt_d   = '0;
      end
      SHIFT_OUT: if (cnt_q == LEN_LAST) begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // After CHAIN_LEN shifts the serialiser holds zeros, so Scan_si idles low without extra gating.
  scan_shreg #(.W(CHAIN_LEN)) u_ser (
    .gclk    (Clock),
    .grst_n  (Reset_n),
    .load_i  (accept),
    .shift_i (state_q == SHIFT_IN),
    .par_i   (pattern_in),
    .ser_i   (1'b0),
    .q_o     (pat_q),
    .nxt_o   (unused_pat_nxt)
  );

  scan_shreg #(.W(CHAIN_LEN)) u_deser (
    .gclk    (Clock),
    .grst_n  (Reset_n),
    .load_i  (accept),
    .shift_i (state_q == SHIFT_OUT),
    .par_i   ('0),
    .ser_i   (Scan_so),
    .q_o     (unused_unl_q),
    .nxt_o   (unl_nxt)
  );

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)    exp_q <= '0;
    else if (accept) exp_q <= expect_in;
  end

  assign pass_d = (unl_nxt == exp_q);
`else
  logic unused_expect;
  assign unused_expect = ^expect_in;
  assign pass_d        = 1'b0;
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      se_q    <= 1'b0;
      cg_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      se_q    <= (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
      cg_q    <= (state_d != IDLE) && (state_d != DONE);
      busy_q  <= (state_d != IDLE) && (state_d != DONE);
      done_q  <= (state_d == DONE);
      if (state_q == SHIFT_OUT && state_d == DONE) begin
        cap_q  <= unl_nxt;
        pass_q <= pass_d;
      end
    end
  end

  assign Scan_en     = se_q;
  assign Scan_si     = pat_q[CHAIN_LEN-1];
  assign cg_en       = cg_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign capture_out = cap_q;

endmodule
